// File: rtl/parking_pkg.sv
// Shared definitions for the parking lot gate control slice.
// Contents:
//   state_e                 - gate transaction state encoding (2 bits)
//   DEFAULT_TOTAL_SPACES    - default lot size
//   DEFAULT_TIMEOUT_CYCLES  - default gate-open timeout in cycles
//   DEFAULT_TMO_W           - default timeout counter width
package parking_pkg;

  typedef enum logic [1:0] {
    IDLE       = 2'd0,
    ENTRY_OPEN = 2'd1,
    EXIT_OPEN  = 2'd2,
    CLOSE      = 2'd3
  } state_e;

  localparam int DEFAULT_TOTAL_SPACES   = 200;
  localparam int DEFAULT_TIMEOUT_CYCLES = 1000;
  localparam int DEFAULT_TMO_W          = 10;

endpackage

// File: rtl/parking_capacity_tracker_if.sv
// Bundle of request, sensor and status signals between the gate controller
// and its environment.
// Signals:
//   entry_en, exit_req  - level requests (entry from entry_checker, exit button)
//   car_passed          - one-cycle loop sensor pulse
//   parking_capacity    - free spaces
//   entry_gate, exit_gate, lot_full, busy - registered status
// Modports:
//   master - environment side (drives requests and sensor)
//   slave  - controller side (drives count, gates and status)
interface parking_capacity_tracker_if;

  logic       entry_en;
  logic       exit_req;
  logic       car_passed;
  logic [7:0] parking_capacity;
  logic       entry_gate;
  logic       exit_gate;
  logic       lot_full;
  logic       busy;

  modport master (
    output entry_en, exit_req, car_passed,
    input  parking_capacity, entry_gate, exit_gate, lot_full, busy
  );

  modport slave (
    input  entry_en, exit_req, car_passed,
    output parking_capacity, entry_gate, exit_gate, lot_full, busy
  );

endinterface

// File: rtl/parking_capacity_tracker_gate_timer.sv
// Gate-open timer: counts enabled cycles since the last clear and flags the
// cycle in which the count reaches LIMIT-1.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   clr        - synchronous clear to zero (wins over en)
//   en         - count enable
//   expired    - high while the count equals LIMIT-1
module gate_timer #(
  parameter int WIDTH = 10,
  parameter int LIMIT = 1000
) (
  input  logic clk,
  input  logic rst_n,
  input  logic clr,
  input  logic en,
  output logic expired
);

  localparam logic [WIDTH-1:0] LAST_C = WIDTH'(LIMIT - 1);

  logic [WIDTH-1:0] count_r;

  // Cycle counter with clear priority over enable.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count_r <= '0;
    end else if (clr) begin
      count_r <= '0;
    end else if (en) begin
      count_r <= count_r + WIDTH'(1);
    end else begin
      count_r <= count_r;
    end
  end

  assign expired = (count_r == LAST_C);

endmodule

// File: rtl/parking_capacity_tracker.sv
// Owns the free-space count of the lot and sequences one gate transaction at
// a time: open gate, wait for car_passed or timeout, update count, close.
// Ports:
//   clk, rst_n - clock, asynchronous active-low reset
//   bus        - slave side of parking_capacity_tracker_if (requests, sensor,
//                registered count/gates/lot_full/busy)
module parking_capacity_tracker
  import parking_pkg::*;
#(
  parameter int TOTAL_SPACES   = DEFAULT_TOTAL_SPACES,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
  parameter int TMO_W          = DEFAULT_TMO_W
) (
  input  logic clk,
  input  logic rst_n,
  parking_capacity_tracker_if.slave bus
);

  localparam logic [7:0] TOTAL_C = 8'(TOTAL_SPACES);

  logic       entry_prev_r;
  logic       exit_prev_r;
  logic       entry_edge_r;
  logic       exit_edge_r;
  state_e     state_r;
  state_e     state_s;
  logic [7:0] cap_r;
  logic [7:0] cap_s;
  logic       lot_full_r;
  logic       busy_r;
  logic       entry_gate_r;
  logic       exit_gate_r;
  logic       timer_en_s;
  logic       timer_clr_s;
  logic       timer_expired_s;

  // Registered rising-edge detection; a level already high at reset release
  // counts as an edge because the history registers reset to 0.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      entry_prev_r <= 1'b0;
      exit_prev_r  <= 1'b0;
      entry_edge_r <= 1'b0;
      exit_edge_r  <= 1'b0;
    end else begin
      entry_prev_r <= bus.entry_en;
      exit_prev_r  <= bus.exit_req;
      entry_edge_r <= bus.entry_en & ~entry_prev_r;
      exit_edge_r  <= bus.exit_req & ~exit_prev_r;
    end
  end

  assign timer_en_s  = (state_r == ENTRY_OPEN) || (state_r == EXIT_OPEN);
  assign timer_clr_s = !timer_en_s;

  gate_timer #(
    .WIDTH (TMO_W),
    .LIMIT (TIMEOUT_CYCLES)
  ) u_gate_timer (
    .clk     (clk),
    .rst_n   (rst_n),
    .clr     (timer_clr_s),
    .en      (timer_en_s),
    .expired (timer_expired_s)
  );

  // Next-state and next-count logic; request edges only matter in IDLE.
  always_comb begin
    state_s = state_r;
    cap_s   = cap_r;
    case (state_r)
      IDLE: begin
        if (exit_edge_r && (cap_r < TOTAL_C)) begin
          state_s = EXIT_OPEN;
        end else if (entry_edge_r && (cap_r != 8'd0)) begin
          state_s = ENTRY_OPEN;
        end else begin
          state_s = IDLE;
        end
      end
      ENTRY_OPEN: begin
        if (bus.car_passed) begin
          state_s = CLOSE;
          cap_s   = (cap_r != 8'd0) ? (cap_r - 8'd1) : cap_r;
        end else if (timer_expired_s) begin
          state_s = CLOSE;
        end else begin
          state_s = ENTRY_OPEN;
        end
      end
      EXIT_OPEN: begin
        if (bus.car_passed) begin
          state_s = CLOSE;
          cap_s   = (cap_r < TOTAL_C) ? (cap_r + 8'd1) : cap_r;
        end else if (timer_expired_s) begin
          state_s = CLOSE;
        end else begin
          state_s = EXIT_OPEN;
        end
      end
      CLOSE: begin
        state_s = IDLE;
      end
      default: begin
        state_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_s;
    end
  end

  // Count and status registers, all derived from the next state/count so
  // they line up with the state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cap_r        <= TOTAL_C;
      lot_full_r   <= (TOTAL_C == 8'd0);
      busy_r       <= 1'b0;
      entry_gate_r <= 1'b0;
      exit_gate_r  <= 1'b0;
    end else begin
      cap_r        <= cap_s;
      lot_full_r   <= (cap_s == 8'd0);
      busy_r       <= (state_s != IDLE);
      entry_gate_r <= (state_s == ENTRY_OPEN);
      exit_gate_r  <= (state_s == EXIT_OPEN);
    end
  end

  assign bus.parking_capacity = cap_r;
  assign bus.lot_full         = lot_full_r;
  assign bus.busy             = busy_r;
  assign bus.entry_gate       = entry_gate_r;
  assign bus.exit_gate        = exit_gate_r;

endmodule
